// File: rtl/register_file.sv
// General-purpose register file: DEPTH x WIDTH storage, two bypassable read ports,
// one byte-masked synchronous write port and a debug read port of stored contents.

// One storage word with per-byte write gating and an asynchronous reset.
module register_file_word #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               we,
    input  logic [WIDTH/8-1:0] byte_en,
    input  logic [WIDTH-1:0]   data,
    output logic [WIDTH-1:0]   q
);
    localparam int NB = WIDTH / 8;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= RESET_VALUE;
        end else if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b]) q[b*8 +: 8] <= data[b*8 +: 8];
            end
        end
    end
endmodule

module register_file #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 32,
    parameter int               ADDR_WIDTH  = 5,
    parameter int               ZERO_REG    = 1,
    parameter int               BYPASS      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WIDTH-1:0]      write_data,
    input  logic [WIDTH/8-1:0]    write_byte_en,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    output logic [WIDTH-1:0]      read_data_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [WIDTH-1:0]      read_data_b,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [WIDTH-1:0]      dbg_data,
    output logic                  write_error
);
    localparam int                  NB      = WIDTH / 8;
    localparam int                  NPORTS  = 3;
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

    logic                              in_range;
    logic                              zero_addr;
    logic                              wr_commit;
    logic [DEPTH-1:0][WIDTH-1:0]       regs;
    logic [NPORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [NPORTS-1:0][WIDTH-1:0]      rd_data;

    // A write only lands when it targets real, writable storage while out of reset;
    // the same qualifier gates the bypass path so both always agree.
    assign in_range  = {1'b0, write_addr} < DEPTH_A;
    assign zero_addr = (ZERO_REG != 0) && (write_addr == '0);
    assign wr_commit = reset && write_enable && in_range && !zero_addr;

    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        if (ZERO_REG != 0 && r == 0) begin : g_zero
            assign regs[r] = '0;
        end else begin : g_word
            register_file_word #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_word (
                .clock   (clock),
                .reset   (reset),
                .we      (wr_commit && (write_addr == ADDR_WIDTH'(r))),
                .byte_en (write_byte_en),
                .data    (write_data),
                .q       (regs[r])
            );
        end
    end

    assign rd_addr = {dbg_addr, read_addr_b, read_addr_a};

    // Port 2 is the debug port and never sees in-flight write data.
    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
        localparam bit CAN_BYP = (p < 2) && (BYPASS != 0);
        logic [WIDTH-1:0] stored;

        // Addresses at or above DEPTH match no entry and fall through to zero.
        always_comb begin
            stored = '0;
            for (int r = 0; r < DEPTH; r++) begin
                if (rd_addr[p] == ADDR_WIDTH'(r)) stored = regs[r];
            end
        end

        if (CAN_BYP) begin : g_byp
            always_comb begin
                rd_data[p] = stored;
                if (wr_commit && rd_addr[p] == write_addr) begin
                    for (int b = 0; b < NB; b++) begin
                        if (write_byte_en[b]) rd_data[p][b*8 +: 8] = write_data[b*8 +: 8];
                    end
                end
            end
        end else begin : g_plain
            assign rd_data[p] = stored;
        end
    end

    assign read_data_a = rd_data[0];
    assign read_data_b = rd_data[1];
    assign dbg_data    = rd_data[2];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) write_error <= 1'b0;
        else        write_error <= write_enable && !in_range;
    end
endmodule

// File: tb/tb_register_file.sv
// Drives two register_file configurations from shared inputs and compares every
// read port and the error flag against an array-based model of the register file.
module tb_register_file;
    logic        clock = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [3:0]  write_byte_en;
    logic [4:0]  read_addr_a, read_addr_b, dbg_addr;
    logic [31:0] a_rda, a_rdb, a_dbg, b_rda, b_rdb, b_dbg;
    logic        a_err, b_err;

    localparam logic [31:0] RV_B = 32'hDEAD_BEEF;

    always #5 clock = ~clock;

    // Instance 0: default configuration. Instance 1: 24 entries, no bypass, plain reg 0.
    register_file u_a (
        .clock(clock), .reset(reset), .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data), .write_byte_en(write_byte_en),
        .read_addr_a(read_addr_a), .read_data_a(a_rda),
        .read_addr_b(read_addr_b), .read_data_b(a_rdb),
        .dbg_addr(dbg_addr), .dbg_data(a_dbg), .write_error(a_err)
    );

    register_file #(
        .DEPTH(24), .ZERO_REG(0), .BYPASS(0), .RESET_VALUE(RV_B)
    ) u_b (
        .clock(clock), .reset(reset), .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data), .write_byte_en(write_byte_en),
        .read_addr_a(read_addr_a), .read_data_a(b_rda),
        .read_addr_b(read_addr_b), .read_data_b(b_rdb),
        .dbg_addr(dbg_addr), .dbg_data(b_dbg), .write_error(b_err)
    );

    int          depth_of [2] = '{32, 24};
    bit          zero_of  [2] = '{1'b1, 1'b0};
    bit          byp_of   [2] = '{1'b1, 1'b0};
    logic [31:0] rv_of    [2] = '{32'h0, RV_B};

    logic [31:0] mem [2][32];
    logic        exp_err [2];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] m = old;
        for (int b = 0; b < 4; b++) if (be[b]) m[b*8 +: 8] = nw[b*8 +: 8];
        return m;
    endfunction

    function automatic logic [31:0] model_read(int d, logic [4:0] addr, bit is_dbg);
        logic [31:0] v;
        if (int'(addr) >= depth_of[d]) return 32'h0;
        if (zero_of[d] && addr == 5'd0) return 32'h0;
        v = mem[d][addr];
        if (!is_dbg && byp_of[d] && reset === 1'b1 && write_enable && addr == write_addr)
            v = merge(v, write_data, write_byte_en);
        return v;
    endfunction

    function automatic logic [31:0] dut_out(int d, int port);
        case (port)
            0:       return d == 0 ? a_rda : b_rda;
            1:       return d == 0 ? a_rdb : b_rdb;
            default: return d == 0 ? a_dbg : b_dbg;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reads(string where);
        logic [4:0] addrs [3];
        addrs = '{read_addr_a, read_addr_b, dbg_addr};
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 3; p++)
                check($sformatf("%s dut%0d port%0d addr%0d", where, d, p, addrs[p]),
                      dut_out(d, p), model_read(d, addrs[p], p == 2));
    endtask

    task automatic check_err(string where);
        check($sformatf("%s dut0 write_error", where), {31'b0, a_err}, {31'b0, exp_err[0]});
        check($sformatf("%s dut1 write_error", where), {31'b0, b_err}, {31'b0, exp_err[1]});
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) mem[d][i] = rv_of[d];
            exp_err[d] = 1'b0;
        end
    endtask

    task automatic model_commit();
        if (!reset) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            exp_err[d] = write_enable && (int'(write_addr) >= depth_of[d]);
            if (write_enable && int'(write_addr) < depth_of[d] && !(zero_of[d] && write_addr == 5'd0))
                mem[d][write_addr] = merge(mem[d][write_addr], write_data, write_byte_en);
        end
    endtask

    // Entered just after a falling edge with inputs already applied.
    task automatic cycle(string where);
        #1 check_reads(where);
        @(posedge clock);
        model_commit();
        #1 check_err(where);
        @(negedge clock);
    endtask

    task automatic set_wr(bit we, logic [4:0] addr, logic [31:0] data, logic [3:0] be);
        write_enable = we; write_addr = addr; write_data = data; write_byte_en = be;
    endtask

    task automatic set_rd(logic [4:0] ra, logic [4:0] rb, logic [4:0] da);
        read_addr_a = ra; read_addr_b = rb; dbg_addr = da;
    endtask

    initial begin
        // Reset held low: a write to reg 5 must be discarded.
        reset = 1'b0;
        model_reset();
        set_wr(1, 5'd5, 32'hFFFF_FFFF, 4'hF);
        set_rd(5'd5, 5'd5, 5'd5);
        @(negedge clock);
        cycle("reset_write");
        reset = 1'b1;
        set_wr(0, 5'd0, 32'h0, 4'h0);
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a), 5'(a));
            #1 check_reads("reset_scan");
        end
        check_err("reset_scan");
        @(negedge clock);

        // Basic write / read.
        set_wr(1, 5'd3, 32'hAABB_CCDD, 4'hF); set_rd(5'd0, 5'd1, 5'd2);
        cycle("wr3");
        set_wr(0, 5'd0, 32'h0, 4'h0); set_rd(5'd3, 5'd1, 5'd3);
        #1 check("rd3 dut0 A", a_rda, 32'hAABB_CCDD);
        check("rd3 dut1 A", b_rda, 32'hAABB_CCDD);
        @(negedge clock);
        set_wr(1, 5'd3, 32'hFFEE_DDCC, 4'hF); set_rd(5'd3, 5'd3, 5'd3);
        cycle("wr3b");
        set_wr(0, 5'd0, 32'h0, 4'h0);
        #1 check("rd3b dut0 B", a_rdb, 32'hFFEE_DDCC);
        check("rd3b dut1 B", b_rdb, 32'hFFEE_DDCC);
        @(negedge clock);

        // Byte enables.
        set_wr(1, 5'd7, 32'h1234_5678, 4'hF); set_rd(5'd7, 5'd0, 5'd7);
        cycle("wr7");
        set_wr(1, 5'd7, 32'hAABB_CCDD, 4'b0101);
        cycle("wr7_be");
        set_wr(0, 5'd0, 32'h0, 4'h0);
        #1 check("be7 dut0 A", a_rda, 32'h12BB_56DD);
        check("be7 dut1 dbg", b_dbg, 32'h12BB_56DD);
        @(negedge clock);
        set_wr(1, 5'd7, 32'hFFFF_FFFF, 4'h0);
        cycle("wr7_nobe");
        set_wr(0, 5'd0, 32'h0, 4'h0);
        #1 check("nobe7 dut0 A", a_rda, 32'h12BB_56DD);
        @(negedge clock);

        // Bypass on dut0, none on dut1; dbg never bypassed.
        set_wr(1, 5'd9, 32'h1111_2222, 4'hF); set_rd(5'd1, 5'd2, 5'd3);
        cycle("wr9");
        set_wr(1, 5'd9, 32'hCAFE_BABE, 4'hF); set_rd(5'd9, 5'd9, 5'd9);
        #1 check("byp dut0 A", a_rda, 32'hCAFE_BABE);
        check("byp dut0 B", a_rdb, 32'hCAFE_BABE);
        check("byp dut0 dbg", a_dbg, 32'h1111_2222);
        check("nobyp dut1 A", b_rda, 32'h1111_2222);
        check("nobyp dut1 B", b_rdb, 32'h1111_2222);
        cycle("byp9");
        set_wr(0, 5'd0, 32'h0, 4'h0);
        #1 check("post9 dut1 A", b_rda, 32'hCAFE_BABE);
        @(negedge clock);

        // Register zero.
        set_wr(1, 5'd0, 32'hFFFF_FFFF, 4'hF); set_rd(5'd0, 5'd0, 5'd0);
        cycle("wr0");
        set_wr(0, 5'd0, 32'h0, 4'h0);
        #1 check("rd0 dut0 A", a_rda, 32'h0);
        check("rd0 dut1 A", b_rda, 32'hFFFF_FFFF);
        @(negedge clock);

        // Out of range for the 24-entry instance only.
        set_wr(1, 5'd30, 32'h0BAD_F00D, 4'hF); set_rd(5'd30, 5'd29, 5'd30);
        cycle("wr30");
        set_wr(0, 5'd0, 32'h0, 4'h0);
        #1 check("err30 dut1 pulse", {31'b0, b_err}, 32'h1);
        check("rd30 dut1 A", b_rda, 32'h0);
        check("rd30 dut0 A", a_rda, 32'h0BAD_F00D);
        @(negedge clock);
        cycle("err30_clear");
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(a), 5'(a));
            #1 check_reads("oor_scan");
        end
        @(negedge clock);

        // Asynchronous reset between edges.
        set_rd(5'd3, 5'd7, 5'd9);
        reset = 1'b0;
        #1 model_reset();
        check("async dut0 A", a_rda, 32'h0);
        check("async dut1 B", b_rdb, RV_B);
        check_reads("async");
        check_err("async");
        reset = 1'b1;
        @(negedge clock);

        // Randomized traffic, biased toward read/write address collisions.
        for (int n = 0; n < 400; n++) begin
            set_wr($urandom_range(0, 3) != 0, 5'($urandom), $urandom, 4'($urandom));
            set_rd($urandom_range(0, 2) == 0 ? write_addr : 5'($urandom),
                   $urandom_range(0, 2) == 0 ? write_addr : 5'($urandom),
                   $urandom_range(0, 2) == 0 ? write_addr : 5'($urandom));
            #1 check_reads("rand");
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                #1 model_reset();
                check_reads("rand_rst");
                check_err("rand_rst");
                reset = 1'b1;
            end
            @(posedge clock);
            model_commit();
            #1 check_err("rand");
            @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
